// File: rtl/estagio_ula_pkg.sv
// Shared encodings for the NCL-style ALU stage: operation codes, dual-rail flag codes, handshake states.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package estagio_ula_pkg;

  // Operation codes; OPR_NULL marks the NULL wavefront on the operand bus
  localparam logic [1:0] OPR_NULL = 2'b00;
  localparam logic [1:0] OPR_ADD  = 2'b01;
  localparam logic [1:0] OPR_SUB  = 2'b10;
  localparam logic [1:0] OPR_AND  = 2'b11;

  // Dual-rail flag codes; 2'b11 is illegal and never driven
  localparam logic [1:0] DR_NULL  = 2'b00;
  localparam logic [1:0] DR_FALSE = 2'b01;
  localparam logic [1:0] DR_TRUE  = 2'b10;

  // Handshake state: which wavefront the output register currently holds
  typedef enum logic {
    S_NULL = 1'b0,
    S_DATA = 1'b1
  } state_t;

  // Status flags as carried on the output, all dual-rail
  typedef struct packed {
    logic [1:0] of;
    logic [1:0] neg;
    logic [1:0] zero;
  } flags_t;

  // Single-rail boolean to dual-rail DATA code
  function automatic logic [1:0] to_dual_rail(input logic t);
    return t ? DR_TRUE : DR_FALSE;
  endfunction

endpackage

// File: rtl/estagio_ula_pipe_ula_core.sv
// Combinational ALU: add/sub/and with single-rail signed-overflow, negative and zero flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing stage decides when the result is captured.
module ula_core
  import estagio_ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       opr,
  output logic [WIDTH-1:0] res,
  output logic             of,
  output logic             neg,
  output logic             zero
);

  // Result and overflow per operation; carry/borrow out of the MSB is dropped
  always_comb begin
    res = '0;
    of  = 1'b0;
    case (opr)
      OPR_ADD: begin
        res = a + b;
        // same-sign operands producing a result of the other sign
        of  = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OPR_SUB: begin
        res = a - b;
        // opposite-sign operands where the result sign departs from a
        of  = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OPR_AND: begin
        res = a & b;
        of  = 1'b0;
      end
      default: begin
        res = '0;
        of  = 1'b0;
      end
    endcase
  end

  assign neg  = res[WIDTH-1];
  assign zero = (res == '0);

endmodule

// File: rtl/estagio_ula_pipe.sv
// ALU pipeline stage emulating the NCL four-phase DATA/NULL handshake with dual-rail status flags.
// Latency: 1 cycle from accepted DATA (or NULL) wavefront to registered outputs.
// Backpressure: DATA is captured only while ack_in=0, NULL only while ack_in=1; otherwise outputs hold.
module estagio_ula_pipe
  import estagio_ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       opr,
  input  logic             ack_in,
  output logic [WIDTH-1:0] soma,
  output logic [1:0]       of,
  output logic [1:0]       neg,
  output logic [1:0]       zero,
  output logic             ack_out
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] res_raw;
  logic             of_raw;
  logic             neg_raw;
  logic             zero_raw;
  logic [WIDTH-1:0] soma_nxt;
  flags_t           flags;
  flags_t           flags_nxt;
  logic             in_data;

  // The wavefront type is carried by opr alone
  assign in_data = (opr != OPR_NULL);

  ula_core #(
    .WIDTH (WIDTH)
  ) u_ula_core (
    .a    (a),
    .b    (b),
    .opr  (opr),
    .res  (res_raw),
    .of   (of_raw),
    .neg  (neg_raw),
    .zero (zero_raw)
  );

  // Next-state and next-output selection: capture DATA, clear to NULL, or hold
  always_comb begin
    state_nxt = state;
    soma_nxt  = soma;
    flags_nxt = flags;
    case (state)
      S_NULL: begin
        if (in_data && !ack_in) begin
          state_nxt      = S_DATA;
          soma_nxt       = res_raw;
          flags_nxt.of   = to_dual_rail(of_raw);
          flags_nxt.neg  = to_dual_rail(neg_raw);
          flags_nxt.zero = to_dual_rail(zero_raw);
        end
      end
      S_DATA: begin
        if (!in_data && ack_in) begin
          state_nxt      = S_NULL;
          soma_nxt       = '0;
          flags_nxt.of   = DR_NULL;
          flags_nxt.neg  = DR_NULL;
          flags_nxt.zero = DR_NULL;
        end
      end
      default: begin
        state_nxt = S_NULL;
      end
    endcase
  end

  // Output register; reset forces the NULL wavefront from any state
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_NULL;
      soma  <= '0;
      flags <= '{of: DR_NULL, neg: DR_NULL, zero: DR_NULL};
    end else begin
      state <= state_nxt;
      soma  <= soma_nxt;
      flags <= flags_nxt;
    end
  end

  assign of      = flags.of;
  assign neg     = flags.neg;
  assign zero    = flags.zero;
  assign ack_out = (state == S_DATA);

endmodule

// File: tb/tb_estagio_ula_pipe.sv
// Scoreboard bench for estagio_ula_pipe: directed vectors, DATA/NULL alternation and random traffic.
// Expected outputs come from an arithmetic reference model and are checked one edge later.
// A monitor pops expectations once their target clock edge has occurred.
module tb_estagio_ula_pipe;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic [1:0] opr;
  logic       ack_in;
  logic [7:0] soma;
  logic [1:0] of;
  logic [1:0] neg;
  logic [1:0] zero;
  logic       ack_out;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  soma;
    logic [1:0]  of;
    logic [1:0]  neg;
    logic [1:0]  zero;
    logic        ack;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc_cnt;
  int          checks;
  int          failures;

  // reference model state
  bit          m_data;
  exp_t        m_out;

  estagio_ula_pipe #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .opr     (opr),
    .ack_in  (ack_in),
    .soma    (soma),
    .of      (of),
    .neg     (neg),
    .zero    (zero),
    .ack_out (ack_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [1:0] dr(input bit t);
    return t ? 2'b10 : 2'b01;
  endfunction

  function automatic int sval(input logic [7:0] v);
    return (v >= 8'd128) ? int'(v) - 256 : int'(v);
  endfunction

  // Apply one set of inputs for the next edge and record what that edge must produce
  task automatic step(input logic [7:0] ia, input logic [7:0] ib, input logic [1:0] iop,
                      input logic iack, input logic irst);
    int   sres;
    int   ures;
    bit   ovf;
    exp_t e;
    @(posedge clk);
    #1;
    a = ia; b = ib; opr = iop; ack_in = iack; rst = irst;
    if (irst) begin
      m_data = 0;
      m_out.soma = 8'h00; m_out.of = 2'b00; m_out.neg = 2'b00; m_out.zero = 2'b00;
    end else if (!m_data && iop != 2'b00 && !iack) begin
      case (iop)
        2'b01:   begin sres = sval(ia) + sval(ib); ures = (int'(ia) + int'(ib)) % 256; ovf = (sres > 127 || sres < -128); end
        2'b10:   begin sres = sval(ia) - sval(ib); ures = (int'(ia) - int'(ib) + 256) % 256; ovf = (sres > 127 || sres < -128); end
        default: begin ures = int'(ia & ib); ovf = 0; end
      endcase
      m_data = 1;
      m_out.soma = ures[7:0];
      m_out.of   = dr(ovf);
      m_out.neg  = dr(ures >= 128);
      m_out.zero = dr(ures == 0);
    end else if (m_data && iop == 2'b00 && iack) begin
      m_data = 0;
      m_out.soma = 8'h00; m_out.of = 2'b00; m_out.neg = 2'b00; m_out.zero = 2'b00;
    end
    m_out.ack = m_data;
    e = m_out;
    e.cyc = cyc_cnt + 1;
    sb_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v, input int unsigned c);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s at edge %0d: got %h expected %h", nm, c, act, exp_v);
    end
  endtask

  // Monitor: compare DUT outputs against every expectation whose edge has passed
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_cnt) begin
        e = sb_q.pop_front();
        chk("soma",    soma,            e.soma,          e.cyc);
        chk("of",      {6'd0, of},      {6'd0, e.of},    e.cyc);
        chk("neg",     {6'd0, neg},     {6'd0, e.neg},   e.cyc);
        chk("zero",    {6'd0, zero},    {6'd0, e.zero},  e.cyc);
        chk("ack_out", {7'd0, ack_out}, {7'd0, e.ack},   e.cyc);
      end
    end
  end

  // Stimulus
  initial begin
    logic [1:0] rop;
    logic [7:0] ra;
    logic [7:0] rb;
    int         waited;
    checks = 0; failures = 0; cyc_cnt = 0;
    m_data = 0;
    m_out = '{cyc: 0, soma: 8'h00, of: 2'b00, neg: 2'b00, zero: 2'b00, ack: 1'b0};
    rst = 1'b1; a = 8'h00; b = 8'h00; opr = 2'b00; ack_in = 1'b0;

    // reset, then directed arithmetic vectors separated by NULL wavefronts
    step(8'h00, 8'h00, 2'b00, 1'b0, 1'b1);
    step(8'h00, 8'h00, 2'b00, 1'b0, 1'b1);
    step(8'h5A, 8'hAA, 2'b01, 1'b0, 1'b0);
    step(8'h00, 8'h00, 2'b00, 1'b1, 1'b0);
    step(8'h5A, 8'hAA, 2'b10, 1'b0, 1'b0);
    step(8'h00, 8'h00, 2'b00, 1'b1, 1'b0);
    step(8'h7F, 8'h01, 2'b01, 1'b0, 1'b0);
    step(8'h00, 8'h00, 2'b00, 1'b1, 1'b0);
    step(8'h5A, 8'hA5, 2'b11, 1'b0, 1'b0);
    step(8'h00, 8'h00, 2'b00, 1'b1, 1'b0);
    step(8'h80, 8'h01, 2'b10, 1'b0, 1'b0);
    step(8'h00, 8'h00, 2'b00, 1'b1, 1'b0);

    // holds: DATA with ack_in=1 in S_NULL, NULL in S_NULL, changed DATA in S_DATA
    step(8'h12, 8'h34, 2'b01, 1'b1, 1'b0);
    step(8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
    step(8'h12, 8'h34, 2'b01, 1'b0, 1'b0);
    step(8'hFF, 8'h34, 2'b01, 1'b0, 1'b0);
    step(8'hFF, 8'h34, 2'b01, 1'b1, 1'b0);
    step(8'h00, 8'h00, 2'b00, 1'b0, 1'b0);

    // reset in the middle of a DATA phase
    step(8'h33, 8'h44, 2'b10, 1'b1, 1'b1);
    step(8'h33, 8'h44, 2'b10, 1'b0, 1'b0);
    step(8'h99, 8'h11, 2'b11, 1'b0, 1'b1);
    step(8'h00, 8'h00, 2'b00, 1'b1, 1'b0);

    // well-behaved DATA/NULL alternation for 200 cycles
    for (int i = 0; i < 100; i++) begin
      rop = 2'($urandom_range(1, 3));
      ra = 8'($urandom); rb = 8'($urandom);
      step(ra, rb, rop, 1'b0, 1'b0);
      step(8'h00, 8'h00, 2'b00, 1'b1, 1'b0);
    end

    // unconstrained traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = (rop == 2'b00) ? 8'h00 : 8'($urandom);
      rb = (rop == 2'b00) ? 8'h00 : 8'($urandom);
      step(ra, rb, rop, 1'($urandom), ($urandom_range(0, 24) == 0));
    end

    // drain the scoreboard with a bounded wait
    waited = 0;
    while (sb_q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    if (sb_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/estagio_ula_pipe.md
Name: estagio_ula_pipe

Overview:
Clocked ALU pipeline stage that emulates the NULL Convention Logic (NCL) four-phase DATA/NULL handshake synchronously. It sits between an upstream operand stage and a downstream consumer. It computes an 8-bit add/sub/and result plus dual-rail status flags (overflow, negative, zero). It alternates DATA and NULL wavefronts under control of ack_in and ack_out.

Parameters:
- WIDTH, 8, operand/result width; flags always 2 bits (dual-rail).

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A; all-zero during NULL.
- b  input  WIDTH  operand B; all-zero during NULL.
- opr  input  2  operation; 2'b00 = NULL wavefront, 01 = ADD, 10 = SUB (a-b), 11 = AND.
- ack_in  input  1  downstream acknowledge; 0 = downstream requests DATA, 1 = downstream holds DATA and requests NULL.
- soma  output  WIDTH  registered result; 0 during NULL.
- of  output  2  dual-rail signed overflow flag.
- neg  output  2  dual-rail negative flag.
- zero  output  2  dual-rail zero flag.
- ack_out  output  1  acknowledge to upstream; 1 = stage holds DATA, 0 = stage holds NULL.

Behaviour:
- Dual-rail flag code: 2'b00 = NULL, 2'b01 = FALSE, 2'b10 = TRUE; 2'b11 is never driven.
- Input phase is decided by opr only: opr==00 means input NULL; any other value means input DATA.
- The stage has two states, S_NULL and S_DATA, held in one output register.
- Reset (rst=1 at posedge): S_NULL, soma=0, of=neg=zero=2'b00, ack_out=0. Reset overrides every other condition, including reset in the middle of a DATA phase.
- Transition S_NULL->S_DATA occurs at a posedge when the input is DATA and ack_in==0.
  - soma, of, neg, zero and ack_out=1 are captured together on that edge.
  - Latency is 1 cycle.
- Transition S_DATA->S_NULL occurs at a posedge when the input is NULL and ack_in==1.
  - The stage clears soma to 0, all flags to 2'b00, and ack_out to 0.
- In every other case all outputs hold. Specifically:
  - DATA input with ack_in==1 while in S_NULL: no capture.
  - NULL input while in S_NULL: no change.
  - Changed DATA input while in S_DATA: ignored; the captured DATA is kept.
- Arithmetic is modulo 2^WIDTH:
  - ADD: soma = a+b.
  - SUB: soma = a-b.
  - AND: soma = a&b.
- of is TRUE on two's-complement signed overflow:
  - ADD: operands have the same sign and the result sign differs.
  - SUB: operands have different signs and the result sign differs from a.
  - AND: of is always FALSE.
- Carry/borrow out of the MSB is discarded and is not reported.
- neg = result MSB; zero = (result==0). Both are encoded dual-rail as above.
- In S_DATA every flag is either FALSE or TRUE; it is never NULL.
- All outputs come straight from registers; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package estagio_ula_pkg holds:
  - opr encodings: OPR_NULL, OPR_ADD, OPR_SUB, OPR_AND.
  - dual-rail constants: DR_NULL=2'b00, DR_FALSE=2'b01, DR_TRUE=2'b10.
  - state encoding: S_NULL, S_DATA.
- One combinational sub-module, ula_core, is natural:
  - inputs: a, b, opr.
  - outputs: raw result plus single-rail of/neg/zero.
  - The top level holds the handshake register and the dual-rail encoding.

Test Plan:
- Reset, then a=8'h5A, b=8'hAA, opr=01, ack_in=0 -> next edge: soma=8'h04, of=01, neg=01, zero=01, ack_out=1.
- From S_DATA, set a=b=0, opr=00, ack_in=1 -> next edge: soma=0, of=neg=zero=00, ack_out=0. Then repeat the DATA/NULL alternation for 200 cycles with correct toggling every time.
- SUB a=8'h5A, b=8'hAA -> soma=8'hB0, of=10, neg=10, zero=01. ADD a=8'h7F, b=8'h01 -> soma=8'h80, of=10, neg=10.
- AND a=8'h5A, b=8'hA5 -> soma=8'h00, zero=10, neg=01, of=01.
- Hold checks:
  - DATA input with ack_in=1 in S_NULL -> outputs stay NULL.
  - In S_DATA, change a to 8'hFF while ack_in=0 -> soma unchanged.
- Assert rst while in S_DATA -> next edge: all outputs NULL, ack_out=0, regardless of ack_in and opr.
